// File: rtl/xor_cipher_tx_serializer.sv
// xor_cipher_tx_serializer
//    Byte-to-bit serializer feeding the plaintext side of dual_xor_stream_cipher.
//    Words arrive over a valid/ready handshake into a one-word holding register.
//    From there they move into a shift register and go out one bit per
//    programmable bit period.
//
// Ports
//    clk, rst     : system clock, synchronous active-high reset
//    div          : bit period minus 1 in clk cycles, latched when a word loads
//    msb_first    : 1 = MSB first, 0 = LSB first, latched when a word loads
//    s_valid      : upstream word valid
//    s_data       : upstream plaintext word
//    s_ready      : holding register empty (registered)
//    tx_p         : plaintext bit to the cipher
//    tx_en        : one-cycle strobe at the start of each bit period
//    bit_last     : high with tx_en on the final bit of a word
//    busy         : shifting or a word is held
//    word_cnt     : count of fully issued words (wraps)
module xor_cipher_tx_serializer #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DIV_W  = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIV_W-1:0]  div,
   input  logic              msb_first,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              tx_p,
   output logic              tx_en,
   output logic              bit_last,
   output logic              busy,
   output logic [CNT_W-1:0]  word_cnt
);

   localparam int unsigned      IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   typedef enum logic {S_IDLE, S_SHIFT} state_e;

   state_e              state_q;
   logic                hold_valid_q;
   logic [DATA_W-1:0]   hold_q;
   logic [DATA_W-1:0]   shreg_q;
   logic [IDX_W-1:0]    bit_idx_q;
   logic [DIV_W-1:0]    div_lat_q;
   logic [DIV_W-1:0]    div_cnt_q;
   logic                msb_q;
   logic                s_ready_q;
   logic                tx_p_q;
   logic                tx_en_q;
   logic                bit_last_q;
   logic                busy_q;
   logic [CNT_W-1:0]    word_cnt_q;

   logic                accept;
   logic                period_end;
   logic                word_end;
   logic                load;
   logic                hold_valid_d;
   logic                shifting_d;
   logic [IDX_W-1:0]    bit_idx_d;

   // Next-cycle view of hold/state, so that s_ready and busy can be registered
   // and still be exact in the cycle they describe.
   always_comb begin
      accept       = s_valid && s_ready_q;
      period_end   = (state_q == S_SHIFT) && (div_cnt_q == '0);
      word_end     = period_end && (bit_idx_q == LAST_IDX);
      load         = hold_valid_q && ((state_q == S_IDLE) || word_end);
      hold_valid_d = accept || (hold_valid_q && !load);
      shifting_d   = load || ((state_q == S_SHIFT) && !word_end);
      bit_idx_d    = bit_idx_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         hold_valid_q <= 1'b0;
         hold_q       <= '0;
         shreg_q      <= '0;
         bit_idx_q    <= '0;
         div_lat_q    <= '0;
         div_cnt_q    <= '0;
         msb_q        <= 1'b0;
         s_ready_q    <= 1'b1;
         tx_p_q       <= 1'b0;
         tx_en_q      <= 1'b0;
         bit_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         word_cnt_q   <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         s_ready_q    <= !hold_valid_d;
         busy_q       <= shifting_d || hold_valid_d;
         tx_en_q      <= 1'b0;
         bit_last_q   <= 1'b0;

         if (accept) begin
            hold_q <= s_data;
         end

         if (tx_en_q && bit_last_q) begin
            word_cnt_q <= word_cnt_q + 1'b1;
         end

         if (load) begin
            // Load from IDLE or straight at the end of the previous word, so
            // back-to-back words have no idle cycle between them.
            state_q    <= S_SHIFT;
            div_lat_q  <= div;
            div_cnt_q  <= div;
            msb_q      <= msb_first;
            bit_idx_q  <= '0;
            tx_p_q     <= msb_first ? hold_q[DATA_W-1] : hold_q[0];
            shreg_q    <= msb_first ? (hold_q << 1) : (hold_q >> 1);
            tx_en_q    <= 1'b1;
            bit_last_q <= (LAST_IDX == '0);
         end else begin
            case (state_q)
               S_IDLE: begin
                  tx_p_q <= 1'b0;
               end
               S_SHIFT: begin
                  if (!period_end) begin
                     div_cnt_q <= div_cnt_q - 1'b1;
                  end else if (word_end) begin
                     state_q <= S_IDLE;
                     tx_p_q  <= 1'b0;
                  end else begin
                     bit_idx_q  <= bit_idx_d;
                     div_cnt_q  <= div_lat_q;
                     tx_p_q     <= msb_q ? shreg_q[DATA_W-1] : shreg_q[0];
                     shreg_q    <= msb_q ? (shreg_q << 1) : (shreg_q >> 1);
                     tx_en_q    <= 1'b1;
                     bit_last_q <= (bit_idx_d == LAST_IDX);
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign s_ready  = s_ready_q;
   assign tx_p     = tx_p_q;
   assign tx_en    = tx_en_q;
   assign bit_last = bit_last_q;
   assign busy     = busy_q;
   assign word_cnt = word_cnt_q;

endmodule
